// File: rtl/client_if_pkg.sv
// Shared encodings and helpers for the client read/write request interface.
package client_if_pkg;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam int MAX_BYTES = 128;

  // (1 << size) ones, placed at the lane aligned down to the access size.
  function automatic logic [MAX_BYTES-1:0] byte_mask(input logic [2:0] size, input logic [6:0] lane);
    logic [7:0]           nbytes;
    logic [6:0]           base;
    logic [MAX_BYTES-1:0] ones;
    nbytes = 8'd1 << size;
    base   = lane & ~(nbytes[6:0] - 7'd1);
    ones   = (nbytes == 8'd128) ? '1 : ((MAX_BYTES'(1) << nbytes) - MAX_BYTES'(1));
    return ones << base;
  endfunction

endpackage

// File: rtl/client_rd_fifo2.sv
// Two-entry synchronous FIFO with occupancy count; caller never pushes when full
// unless it pops in the same cycle.
module client_rd_fifo2 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] entry0, entry1;
  logic         wr_ptr, rd_ptr;
  logic [1:0]   cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      if (wr_ptr) entry1 <= push_data;
      else        entry0 <= push_data;
    end
  end

  assign head  = rd_ptr ? entry1 : entry0;
  assign count = cnt;

endmodule

// File: rtl/client_mem_responder.sv
// Responder end of the client read/write burst interface, backed by a single-port
// synchronous memory with 1-cycle read latency; one burst in flight at a time.
module client_mem_responder
  import client_if_pkg::*;
#(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32,
  parameter int MEM_AWIDTH = 14
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    read_request_valid,
  output logic                    read_request_ready,
  input  logic [AXI_AWIDTH-1:0]   read_addr,
  input  logic [31:0]             read_len,
  input  logic [2:0]              read_size,
  input  logic [1:0]              read_burst,
  output logic [AXI_DWIDTH-1:0]   read_data,
  output logic                    read_data_valid,
  input  logic                    read_data_ready,
  input  logic                    write_request_valid,
  output logic                    write_request_ready,
  input  logic [AXI_AWIDTH-1:0]   write_addr,
  input  logic [31:0]             write_len,
  input  logic [2:0]              write_size,
  input  logic [1:0]              write_burst,
  input  logic [AXI_DWIDTH-1:0]   write_data,
  input  logic                    write_data_valid,
  output logic                    write_data_ready,
  output logic                    mem_en,
  output logic [AXI_DWIDTH/8-1:0] mem_we,
  output logic [MEM_AWIDTH-1:0]   mem_addr,
  output logic [AXI_DWIDTH-1:0]   mem_din,
  input  logic [AXI_DWIDTH-1:0]   mem_dout
);

  localparam int NB  = AXI_DWIDTH / 8;
  localparam int OFF = $clog2(NB);

  function automatic logic [2:0] clamp_size(input logic [2:0] s);
    return (int'(s) > OFF) ? 3'(OFF) : s;
  endfunction

  state_t                  state, state_nxt;
  logic                    last_read_q;
  logic [AXI_AWIDTH-1:0]   addr_q, addr_step;
  logic [2:0]              size_q;
  logic                    incr_q;
  logic [31:0]             rem_q, pop_rem_q;
  logic                    issue_done_q, inflight_q;

  logic                    grant_read, grant_write, idle;
  logic                    rd_hs, wr_hs, rd_issue, rd_pop, wr_beat;
  logic                    fifo_push, fifo_pop, fifo_empty;
  logic [1:0]              fifo_cnt, occ;
  logic [AXI_DWIDTH-1:0]   fifo_head;
  logic [6:0]              lane;

  // Ties alternate; last_read_q resets low so the first tie goes to read.
  assign grant_read  = read_request_valid && (!write_request_valid || !last_read_q);
  assign grant_write = write_request_valid && !grant_read;
  assign idle        = (state == ST_IDLE);

  assign read_request_ready  = rstn && idle && grant_read;
  assign write_request_ready = rstn && idle && grant_write;
  assign rd_hs = read_request_valid && read_request_ready;
  assign wr_hs = write_request_valid && write_request_ready;

  assign addr_step = incr_q ? addr_q + (AXI_AWIDTH'(1) << size_q) : addr_q;
  assign mem_addr  = addr_q[MEM_AWIDTH+OFF-1:OFF];
  assign lane      = 7'(addr_q & AXI_AWIDTH'(NB - 1));

  // Issue only while the FIFO can absorb every outstanding word.
  assign occ        = fifo_cnt + {1'b0, inflight_q};
  assign rd_issue   = (state == ST_READ) && !issue_done_q && (occ < 2'd2);
  assign fifo_empty = (fifo_cnt == 2'd0);

  // With the FIFO empty the returning word is presented straight from memory,
  // which gives first data two cycles after the handshake and 1 beat/cycle.
  assign read_data_valid = !fifo_empty || inflight_q;
  assign read_data       = fifo_empty ? mem_dout : fifo_head;
  assign rd_pop          = read_data_valid && read_data_ready;
  assign fifo_pop        = rd_pop && !fifo_empty;
  assign fifo_push       = inflight_q && !(fifo_empty && read_data_ready);

  assign write_data_ready = (state == ST_WRITE);
  assign wr_beat          = (state == ST_WRITE) && write_data_valid;

  assign mem_en  = rd_issue || wr_beat;
  assign mem_we  = wr_beat ? NB'(byte_mask(size_q, lane)) : '0;
  assign mem_din = write_data;

  client_rd_fifo2 #(.W(AXI_DWIDTH)) u_rd_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (mem_dout),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_cnt)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (rd_hs)      state_nxt = ST_READ;
        else if (wr_hs) state_nxt = ST_WRITE;
      end
      ST_READ:  if (rd_pop && pop_rem_q == 32'd0) state_nxt = ST_IDLE;
      ST_WRITE: if (wr_beat && rem_q == 32'd0)    state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_read_q  <= 1'b0;
      addr_q       <= '0;
      size_q       <= 3'd0;
      incr_q       <= 1'b0;
      rem_q        <= 32'd0;
      pop_rem_q    <= 32'd0;
      issue_done_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      inflight_q <= rd_issue;
      if (rd_hs) begin
        addr_q       <= read_addr;
        size_q       <= clamp_size(read_size);
        incr_q       <= (read_burst != BURST_FIXED);
        rem_q        <= read_len;
        pop_rem_q    <= read_len;
        issue_done_q <= 1'b0;
        last_read_q  <= 1'b1;
      end else if (wr_hs) begin
        addr_q       <= write_addr;
        size_q       <= clamp_size(write_size);
        incr_q       <= (write_burst != BURST_FIXED);
        rem_q        <= write_len;
        issue_done_q <= 1'b0;
        last_read_q  <= 1'b0;
      end
      if (rd_issue) begin
        addr_q <= addr_step;
        if (rem_q == 32'd0) issue_done_q <= 1'b1;
        else                rem_q        <= rem_q - 32'd1;
      end
      if (wr_beat) begin
        addr_q <= addr_step;
        rem_q  <= rem_q - 32'd1;
      end
      if (rd_pop) pop_rem_q <= pop_rem_q - 32'd1;
    end
  end

endmodule

// File: doc/client_mem_responder.md
Name: client_mem_responder

Overview:
- Responder (server) end of the client read/write request interface, the interface that DMA and accelerator requests are multiplexed onto.
- Accepts one read or write burst at a time and serves it from a single-port synchronous memory with 1-cycle read latency.
- Used as a memory-side endpoint for accelerator/DMA integration and as a bus-model target in block-level benches.

Parameters:
- AXI_AWIDTH, 32, byte-address width of the request interface.
- AXI_DWIDTH, 32, data width; a power of two, at least 8. OFF = log2(AXI_DWIDTH/8).
- MEM_AWIDTH, 14, word-address width of the backing memory.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- read_request_valid  in  1  read burst request
- read_request_ready  out  1  read request accepted
- read_addr  in  AXI_AWIDTH  start byte address
- read_len  in  32  beats minus one
- read_size  in  3  log2 bytes per beat
- read_burst  in  2  0 = FIXED, 1 = INCR, 2/3 treated as INCR
- read_data  out  AXI_DWIDTH  beat data
- read_data_valid  out  1  beat valid
- read_data_ready  in  1  beat accepted
- write_request_valid  in  1  write burst request
- write_request_ready  out  1  write request accepted
- write_addr, write_len, write_size, write_burst  in  AXI_AWIDTH/32/3/2  same meaning as the read fields
- write_data  in  AXI_DWIDTH  beat data
- write_data_valid  in  1  beat valid
- write_data_ready  out  1  beat accepted
- mem_en  out  1  memory access enable
- mem_we  out  AXI_DWIDTH/8  byte write enables
- mem_addr  out  MEM_AWIDTH  word address
- mem_din  out  AXI_DWIDTH  write data to memory
- mem_dout  in  AXI_DWIDTH  read data, valid one cycle after mem_en with mem_we == 0

Behaviour:
- Reset (async, rstn low):
  - State goes to IDLE; FIFO and in-flight flag are cleared; grant pointer favours read.
  - All outputs 0: read_request_ready, write_request_ready, read_data_valid, write_data_ready, mem_en, mem_we.
  - Reset mid-burst abandons the burst; no partial completion.
- States: IDLE, READ, WRITE.
- IDLE arbitration (combinational):
  - Only one valid: grant it.
  - Both valid: grant opposite of last served; first after reset is read.
  - read_request_ready = IDLE && grant_read; write_request_ready = IDLE && grant_write.
  - On handshake: latch addr, len (into remaining counter), size and burst; go to READ or WRITE next cycle.
- Address: byte address register; mem_addr = addr[MEM_AWIDTH+OFF-1:OFF].
  - Per beat, INCR adds (1 << size) modulo 2^AXI_AWIDTH, so the address wraps silently.
  - FIXED leaves the address unchanged.
  - A size larger than OFF is clamped to OFF.
- READ:
  - 2-entry output FIFO (skid) plus a 1-bit in-flight flag.
  - Issue mem_en with mem_we = 0 when beats remain to issue and (fifo_count + inflight) < 2.
  - mem_dout is pushed into the FIFO the cycle after an issue.
  - read_data and read_data_valid come from the FIFO head; pop on valid && ready.
  - Read data is always the full word, regardless of size.
  - Throughput is 1 beat/cycle with ready held high. First beat is visible 2 cycles after the request handshake (cycle 1: issue; cycle 2: valid).
  - Return to IDLE the cycle after the last beat pops. Exactly len+1 beats are delivered.
- WRITE:
  - write_data_ready = 1 throughout WRITE.
  - On each write_data_valid, in the same cycle: mem_en = 1, mem_din = write_data, and mem_we = a mask of (1 << size) bytes starting at lane addr[OFF-1:0], aligned down to size.
  - Return to IDLE after beat len+1; no write response.
- remaining is a 32-bit down-counter; the last beat is at remaining == 0, so len = 0xFFFFFFFF is legal.
- Requests arriving outside IDLE are held off (ready = 0); request fields must stay stable while valid.

Decomposition:
- Shared package (client_if_pkg):
  - Burst encodings: BURST_FIXED = 2'd0, BURST_INCR = 2'd1.
  - State encoding.
  - Function that computes the byte-enable mask from size and low address bits.
- One sub-module: client_rd_fifo2, a 2-entry synchronous FIFO with count output and async active-low reset.

Test Plan:
- INCR read, addr 0x100, len 3, size 2, memory words 0x40..0x43 preset to A0..A3, read_data_ready = 1 -> mem_addr 0x40,0x41,0x42,0x43 on consecutive cycles; 4 beats A0..A3 on back-to-back cycles, first valid 2 cycles after handshake; IDLE afterwards.
- Same read with read_data_ready toggled 1,0,0,1,... -> no beat lost or duplicated; in-flight + FIFO never exceeds 2; order preserved.
- FIXED write, addr 0x20, len 2, data 11,22,33 -> three writes to mem_addr 0x08 with mem_we = 4'hF; final word 33.
- INCR write, size 0, addr 0x3, len 1 -> mem_we 4'b1000 at word 0, then 4'b0001 at word 1.
- Read and write requests valid in the same cycle after reset -> read served first, then write, then an alternating grant on the next tie.
- rstn dropped during beat 2 of a len-7 read -> all outputs 0 immediately; after release, a new len-0 write completes normally.
